// File: rtl/reflet_fifo_periph_pkg.sv
// ============================================================================
// reflet_fifo_periph_pkg -- register map and status layout shared by the
// reflet FIFO peripheral and its storage core.
// Revision: 1.0
// ============================================================================
`default_nettype none

package reflet_fifo_periph_pkg;

  // Register offsets relative to base_addr
  localparam int REG_DATA = 0;
  localparam int REG_CTRL = 1;

  // Status word bit positions (DATA register read)
  localparam int STAT_EMPTY    = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_OVERFLOW = 2;

  // Control word bit positions (CTRL register write)
  localparam int CTRL_CLR_OVF = 0;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_DATA = 2'd1,
    SEL_CTRL = 2'd2
  } reg_sel_e;

endpackage

`default_nettype wire

// File: rtl/reflet_fifo_core.sv
// ============================================================================
// reflet_fifo_core -- circular-buffer storage with read/write pointers and an
// occupancy counter; accepts push and pop together in any state.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reflet_fifo_core #(
  parameter int WORD_SIZE = 8,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [WORD_SIZE-1:0]       i_data,
  input  logic                       i_pop,
  output logic [WORD_SIZE-1:0]       o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

  logic [WORD_SIZE-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [CNT_W-1:0]     r_count;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_depth);

  // When full, a same-cycle pop frees the slot the push lands in.
  assign w_do_pop  = i_pop && !w_empty && !reset;
  assign w_do_push = i_push && (!w_full || w_do_pop) && !reset;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

`default_nettype wire

// File: rtl/reflet_fifo_periph.sv
// ============================================================================
// reflet_fifo_periph -- CPU-writable FIFO with a streaming output port, a
// status/count register pair and a sticky overflow flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reflet_fifo_periph
  import reflet_fifo_periph_pkg::*;
#(
  parameter int                 addr_size = 8,
  parameter logic [addr_size-1:0] base_addr = 8'h80,
  parameter int                 word_size = 8,
  parameter int                 depth     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [addr_size-1:0]   addr,
  input  logic [word_size-1:0]   data_in,
  input  logic                   write_en,
  output logic [word_size-1:0]   data_out,
  output logic [word_size-1:0]   ext_data,
  output logic                   ext_valid,
  input  logic                   ext_ready,
  output logic [$clog2(depth):0] count,
  output logic                   overflow
);

  localparam logic [addr_size-1:0] c_data_addr = base_addr + addr_size'(REG_DATA);
  localparam logic [addr_size-1:0] c_ctrl_addr = base_addr + addr_size'(REG_CTRL);

  reg_sel_e                 w_sel;
  logic                     w_push;
  logic                     w_clr_ovf;
  logic                     w_drop;
  logic                     w_full;
  logic                     w_empty;
  logic [$clog2(depth):0]   w_count;
  logic [word_size-1:0]     w_status;
  logic                     r_overflow;
  logic [word_size-1:0]     r_data_out;

  always_comb begin
    w_sel = SEL_NONE;
    if (addr == c_data_addr) begin
      w_sel = SEL_DATA;
    end else if (addr == c_ctrl_addr) begin
      w_sel = SEL_CTRL;
    end
  end

  assign w_push    = write_en && (w_sel == SEL_DATA);
  assign w_clr_ovf = write_en && (w_sel == SEL_CTRL) && data_in[CTRL_CLR_OVF];
  // Full is never empty, so any ext_ready while full is a real pop.
  assign w_drop    = w_push && w_full && !ext_ready;

  reflet_fifo_core #(
    .WORD_SIZE (word_size),
    .DEPTH     (depth)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (data_in),
    .i_pop   (ext_ready),
    .o_head  (ext_data),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (w_clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  always_comb begin
    w_status                = '0;
    w_status[STAT_EMPTY]    = w_empty;
    w_status[STAT_FULL]     = w_full;
    w_status[STAT_OVERFLOW] = r_overflow;
  end

  // Unselected reads return zero so several peripherals can be OR-ed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_out <= '0;
    end else begin
      case (w_sel)
        SEL_DATA: r_data_out <= w_status;
        SEL_CTRL: r_data_out <= word_size'(w_count);
        default:  r_data_out <= '0;
      endcase
    end
  end

  assign data_out  = r_data_out;
  assign ext_valid = !w_empty;
  assign count     = w_count;
  assign overflow  = r_overflow;

endmodule

`default_nettype wire
